// File: rtl/set_time_ctrl.sv
// set_time_ctrl: sequences a user edit of a 6-digit BCD time (HHMMSS) and commits it.
// Optional inactivity abort in EDIT is enabled by defining SET_TIME_TIMEOUT_EN.
module set_time_ctrl #(
    parameter int BLINK_DIV = 25_000_000,
    parameter int TIMEOUT   = 500_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] time_in,
    output logic [23:0] edit_time,
    output logic [2:0]  cursor,
    output logic        blank,
    output logic        editing,
    output logic        load,
    output logic [23:0] time_out
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_nx;

    logic [23:0] edit_nx;
    logic [23:0] time_out_nx;
    logic [2:0]  cursor_nx;
    logic        blank_nx;
    logic        editing_nx;
    logic        load_nx;

    logic        do_next;
    logic        do_inc;
    logic        do_dec;
    logic        accepted;
    logic        timeout_hit;

    logic [3:0]  dig;
    logic [3:0]  dig_max;
    logic [3:0]  dig_new;
    logic [23:0] edited;

    // Any button press while editing counts as user activity
    assign accepted = (state == EDIT) &&
                      (btn_mode || btn_next || btn_inc || btn_dec);

`ifdef SET_TIME_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] idle_cnt;

    // A button in the same cycle as the last idle count keeps the edit alive
    assign timeout_hit = (state == EDIT) && !accepted &&
                         (idle_cnt == IDLE_LAST);

    // Inactivity counter: zero outside EDIT, restarts on every accepted button
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != EDIT || accepted || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // No inactivity abort in this build; TIMEOUT has no effect
    assign timeout_hit = 1'b0 && (TIMEOUT > 0);
`endif

    // One action per cycle in EDIT: mode beats next beats inc beats dec
    always_comb begin
        do_next = 1'b0;
        do_inc  = 1'b0;
        do_dec  = 1'b0;
        if (state == EDIT && !btn_mode) begin
            if (btn_next) begin
                do_next = 1'b1;
            end else if (btn_inc) begin
                do_inc = 1'b1;
            end else if (btn_dec) begin
                do_dec = 1'b1;
            end
        end
    end

    // Select the cursor digit and its legal upper bound
    always_comb begin
        dig     = edit_time[3:0];
        dig_max = 4'd9;
        case (cursor)
            3'd5: begin
                dig     = edit_time[23:20];
                dig_max = 4'd2;
            end
            3'd4: begin
                dig     = edit_time[19:16];
                dig_max = (edit_time[23:20] == 4'd2) ? 4'd3 : 4'd9;
            end
            3'd3: begin
                dig     = edit_time[15:12];
                dig_max = 4'd5;
            end
            3'd2: begin
                dig     = edit_time[11:8];
                dig_max = 4'd9;
            end
            3'd1: begin
                dig     = edit_time[7:4];
                dig_max = 4'd5;
            end
            default: begin
                dig     = edit_time[3:0];
                dig_max = 4'd9;
            end
        endcase
    end

    // Wrap the selected digit within its range, then clamp hours to 23
    always_comb begin
        dig_new = dig;
        if (do_inc) begin
            dig_new = (dig >= dig_max) ? 4'd0 : dig + 4'd1;
        end else if (do_dec) begin
            dig_new = (dig == 4'd0 || dig > dig_max) ? dig_max : dig - 4'd1;
        end

        edited = edit_time;
        case (cursor)
            3'd5:    edited[23:20] = dig_new;
            3'd4:    edited[19:16] = dig_new;
            3'd3:    edited[15:12] = dig_new;
            3'd2:    edited[11:8]  = dig_new;
            3'd1:    edited[7:4]   = dig_new;
            default: edited[3:0]   = dig_new;
        endcase

        if (edited[23:20] == 4'd2 && edited[19:16] > 4'd3) begin
            edited[19:16] = 4'd3;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (btn_mode) begin
                    state_nx = EDIT;
                end
            end
            EDIT: begin
                if (btn_mode) begin
                    state_nx = COMMIT;
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                end
            end
            COMMIT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Next values for every registered output
    always_comb begin
        edit_nx      = edit_time;
        cursor_nx    = cursor;
        blink_cnt_nx = blink_cnt;
        blank_nx     = blank;
        time_out_nx  = time_out;
        editing_nx   = (state_nx == EDIT);
        load_nx      = (state_nx == COMMIT);

        case (state)
            IDLE: begin
                if (btn_mode) begin
                    edit_nx      = time_in;
                    cursor_nx    = 3'd5;
                    blink_cnt_nx = '0;
                    blank_nx     = 1'b0;
                end
            end
            EDIT: begin
                if (btn_mode) begin
                    time_out_nx = edit_time;
                end else if (do_next) begin
                    cursor_nx = (cursor == 3'd0) ? 3'd5 : cursor - 3'd1;
                end else if (do_inc || do_dec) begin
                    edit_nx = edited;
                end

                if (accepted) begin
                    blink_cnt_nx = '0;
                    blank_nx     = 1'b0;
                end else if (blink_cnt == BLINK_LAST) begin
                    blink_cnt_nx = '0;
                    blank_nx     = ~blank;
                end else begin
                    blink_cnt_nx = blink_cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (state_nx != EDIT) begin
            blank_nx = 1'b0;
        end
    end

    // Output and blink registers
    always_ff @(posedge clk) begin
        if (reset) begin
            edit_time <= '0;
            cursor    <= 3'd5;
            blink_cnt <= '0;
            blank     <= 1'b0;
            editing   <= 1'b0;
            load      <= 1'b0;
            time_out  <= '0;
        end else begin
            edit_time <= edit_nx;
            cursor    <= cursor_nx;
            blink_cnt <= blink_cnt_nx;
            blank     <= blank_nx;
            editing   <= editing_nx;
            load      <= load_nx;
            time_out  <= time_out_nx;
        end
    end

endmodule
